// File: rtl/lutram_pkg.sv
// Shared types and helpers for the multi-port LUT RAM with clear engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lutram_pkg;

    // Upper bound on independent read ports a single instance may expose.
    localparam int MAX_NUM_RD = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // LSB index of port k inside a packed bus of w-bit fields.
    function automatic int port_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/lutram_clr_fsm.sv
// Clear-sweep controller: owns IDLE/CLEAR state, sweep counter, BUSY and WE_DROP,
// and muxes the storage write port between the user and the sweep.
// Latency: write strobe is combinational; BUSY follows state; WE_DROP is 1 cycle after the lost write.
// Backpressure: none; user writes arriving while BUSY are discarded and flagged on WE_DROP.
//
// Ports:
//   clk, rst             active clock (already polarity-selected) and sync active-high reset
//   we, waddr, di        user write request
//   clr_req              start a full sweep (honoured in IDLE only)
//   busy, we_drop        sweep-active flag and discarded-write pulse
//   mem_we/waddr/wdata   effective write port to the storage array
module lutram_clr_fsm
    import lutram_pkg::*;
#(
    parameter int                ADDR_W         = 6,
    parameter int                DATA_W         = 4,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] di,
    input  logic              clr_req,
    output logic              busy,
    output logic              we_drop,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state_q;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            we_drop <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            we_drop <= busy & we;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = di;
        case (state_q)
            ST_IDLE: begin
                // A write coinciding with clr_req still lands; the sweep
                // that starts next edge overwrites it.
                mem_we = we;
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = CLEAR_VAL;
                // Natural rollover to 0 coincides with the return to IDLE.
                cnt_nxt   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        // Reset owns the edge: no sweep or user write happens while it is high,
        // so the sweep's first write is on the first edge with rst low.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    assign busy = (state_q == ST_CLEAR);

endmodule

// File: rtl/lutram_mp_clr.sv
// Parametrised multi-read-port distributed RAM with a sequential clear engine.
// Latency: reads combinational (OUT_REG=0) or 1 cycle read-first (OUT_REG=1); writes land on the active edge.
// Backpressure: none; writes issued while BUSY are dropped and reported on WE_DROP.
//
// Ports:
//   CLK, RST          clock (negedge active when IS_CLK_INVERTED) and sync active-high reset
//   WE, WADDR, DI     write port; WADDR also addresses read port DOW
//   RADDR, DO         NUM_RD packed read addresses / data, port k at slice k
//   CLR_REQ, BUSY     start / status of the full-memory clear sweep
//   WE_DROP           one-cycle pulse after a write was discarded during a sweep
module lutram_mp_clr
    import lutram_pkg::*;
#(
    parameter int                                ADDR_W          = 6,
    parameter int                                DATA_W          = 4,
    parameter int                                NUM_RD          = 3,
    parameter int                                OUT_REG         = 0,
    parameter int                                CLEAR_ON_RESET  = 1,
    parameter logic [DATA_W-1:0]                 CLEAR_VAL       = '0,
    parameter logic [(2**ADDR_W)*DATA_W-1:0]     INIT            = '0,
    parameter logic                              IS_CLK_INVERTED = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WADDR,
    input  logic [DATA_W-1:0]        DI,
    output logic [DATA_W-1:0]        DOW,
    input  logic [NUM_RD*ADDR_W-1:0] RADDR,
    output logic [NUM_RD*DATA_W-1:0] DO,
    input  logic                     CLR_REQ,
    output logic                     BUSY,
    output logic                     WE_DROP
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
        $error("lutram_mp_clr: NUM_RD out of range");
    end

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_words();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = INIT[i*DATA_W +: DATA_W];
        end
        return m;
    endfunction

    // Power-up contents come from INIT; reset never touches the array.
    mem_t mem = init_words();

    // Every sequential element runs on this one edge, so a single XOR
    // selects posedge or negedge operation for the whole block.
    logic clk_act;
    assign clk_act = CLK ^ IS_CLK_INVERTED;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    lutram_clr_fsm #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .CLEAR_VAL      (CLEAR_VAL)
    ) u_clr_fsm (
        .clk       (clk_act),
        .rst       (RST),
        .we        (WE),
        .waddr     (WADDR),
        .di        (DI),
        .clr_req   (CLR_REQ),
        .busy      (BUSY),
        .we_drop   (WE_DROP),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata)
    );

    always_ff @(posedge clk_act) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [NUM_RD*DATA_W-1:0] rd_comb;
    logic [DATA_W-1:0]        dow_comb;

    assign dow_comb = mem[WADDR];

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rd_comb[port_lsb(k, DATA_W) +: DATA_W] = mem[RADDR[port_lsb(k, ADDR_W) +: ADDR_W]];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [NUM_RD*DATA_W-1:0] do_q;
        logic [DATA_W-1:0]        dow_q;

        // Sampled alongside the write, so a same-address write returns the old word.
        always_ff @(posedge clk_act) begin
            if (RST) begin
                do_q  <= '0;
                dow_q <= '0;
            end else begin
                do_q  <= rd_comb;
                dow_q <= dow_comb;
            end
        end

        assign DO  = do_q;
        assign DOW = dow_q;
    end else begin : g_async
        assign DO  = rd_comb;
        assign DOW = dow_comb;
    end

endmodule
